blake_job_arb: RTL and testbench

BLAKE_JOB_ARB -- requirements
Module: blake_job_arb

---
 rtl/blake_job_arb_pkg.sv | 13 +
 rtl/blake_tag_fifo.sv | 55 +++++
 rtl/blake_job_arb.sv | 110 +++++++++++
 tb/tb_blake_job_arb.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blake_job_arb_pkg.sv
// rtl/blake_job_arb_pkg.sv - shared state type and default sizing for the BLAKE job arbiter
package blake_job_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

  localparam int ROUNDS_DEF    = 64;
  localparam int LAT_DEF       = 64;
  localparam int TAG_DEPTH_DEF = LAT_DEF / ROUNDS_DEF + 1;

endpackage

// File: rtl/blake_tag_fifo.sv
// rtl/blake_tag_fifo.sv - 1-bit requester tag FIFO; push and pop in the same cycle is legal, even when full
module blake_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          flush,
  input  logic          push,
  input  logic          din,
  input  logic          pop,
  output logic          dout,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/blake_job_arb.sv
// rtl/blake_job_arb.sv - round-robin job arbiter and round sequencer for a shared BLAKE compression engine
module blake_job_arb
  import blake_job_arb_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF,
  parameter int LAT    = LAT_DEF
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       clr,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       eng_load,
  output logic       eng_sel,
  output logic       round_ing,
  output logic [5:0] round_idx,
  input  logic       eng_rdy,
  output logic       rsp0_valid,
  output logic       rsp1_valid,
  output logic [1:0] inflight,
  output logic       err_unexp
);

  localparam int DEPTH = LAT / ROUNDS + 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [5:0]    LAST_IDX = 6'(ROUNDS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  arb_state_t    state, state_nxt;
  logic [5:0]    idx_nxt;
  logic          last_grant;
  logic          win_open;
  logic          space_ok;
  logic          accept;
  logic          pop_ok;
  logic          tag_head;
  logic [CW-1:0] tag_cnt;

  assign win_open = (state == IDLE) || (round_idx == LAST_IDX);
  // A retiring result frees a slot in the same cycle, so a full FIFO can still take a job.
  assign space_ok = (tag_cnt < FULL_CNT) || ((tag_cnt == FULL_CNT) && eng_rdy);

  assign req0_ready = !clr && win_open && space_ok && req0_valid && (!req1_valid || last_grant);
  assign req1_ready = !clr && win_open && space_ok && req1_valid && (!req0_valid || !last_grant);
  assign accept     = req0_ready || req1_ready;
  assign pop_ok     = eng_rdy && (tag_cnt != '0);
  assign inflight   = 2'(tag_cnt);

  blake_tag_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_tag_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .flush (clr),
    .push  (accept),
    .din   (req1_ready),
    .pop   (eng_rdy),
    .dout  (tag_head),
    .count (tag_cnt)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = round_idx;
    if (clr) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else if (accept) begin
      state_nxt = RUN;
      idx_nxt   = '0;
    end else if (state == RUN) begin
      if (round_idx == LAST_IDX) begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end else begin
        idx_nxt = round_idx + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= IDLE;
      round_idx  <= '0;
      round_ing  <= 1'b0;
      eng_load   <= 1'b0;
      eng_sel    <= 1'b0;
      last_grant <= 1'b1;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      err_unexp  <= 1'b0;
    end else begin
      state      <= state_nxt;
      round_idx  <= idx_nxt;
      round_ing  <= (state_nxt == RUN);
      eng_load   <= accept;
      if (accept) begin
        eng_sel    <= req1_ready;
        last_grant <= req1_ready;
      end
      rsp0_valid <= pop_ok && !clr && !tag_head;
      rsp1_valid <= pop_ok && !clr && tag_head;
      if (eng_rdy && (tag_cnt == '0)) err_unexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_blake_job_arb.sv
// tb/tb_blake_job_arb.sv - directed self-checking bench for blake_job_arb at default parameters
module tb_blake_job_arb;

  logic       clk;
  logic       rstb;
  logic       clr;
  logic       req0_valid;
  logic       req1_valid;
  logic       req0_ready;
  logic       req1_ready;
  logic       eng_load;
  logic       eng_sel;
  logic       round_ing;
  logic [5:0] round_idx;
  logic       eng_rdy;
  logic       rsp0_valid;
  logic       rsp1_valid;
  logic [1:0] inflight;
  logic       err_unexp;

  int checks;
  int errors;

  blake_job_arb dut (
    .clk        (clk),
    .rstb       (rstb),
    .clr        (clr),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .eng_load   (eng_load),
    .eng_sel    (eng_sel),
    .round_ing  (round_ing),
    .round_idx  (round_idx),
    .eng_rdy    (eng_rdy),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .inflight   (inflight),
    .err_unexp  (err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n cycles while the job runs, confirming round_ing never drops.
  task automatic run_rounds(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, int'(round_ing), 1);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rstb       = 1'b0;
    clr        = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    eng_rdy    = 1'b0;
    tick();
    tick();

    chk("rst_ready0", int'(req0_ready), 0);
    chk("rst_ready1", int'(req1_ready), 0);
    chk("rst_load", int'(eng_load), 0);
    chk("rst_sel", int'(eng_sel), 0);
    chk("rst_round_ing", int'(round_ing), 0);
    chk("rst_round_idx", int'(round_idx), 0);
    chk("rst_rsp0", int'(rsp0_valid), 0);
    chk("rst_rsp1", int'(rsp1_valid), 0);
    chk("rst_inflight", int'(inflight), 0);
    chk("rst_err", int'(err_unexp), 0);

    rstb = 1'b1;
    tick();

    // Single requester job, full round sequence.
    req0_valid = 1'b1;
    #1;
    chk("a_ready0", int'(req0_ready), 1);
    chk("a_ready1", int'(req1_ready), 0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("a_load", int'(eng_load), 1);
    chk("a_sel", int'(eng_sel), 0);
    chk("a_round_ing", int'(round_ing), 1);
    chk("a_idx0", int'(round_idx), 0);
    chk("a_inflight", int'(inflight), 1);
    run_rounds(30, "a_run");
    req1_valid = 1'b1;
    #1;
    chk("a_mid_ready1", int'(req1_ready), 0);
    req1_valid = 1'b0;
    run_rounds(33, "a_run");
    chk("a_idx63", int'(round_idx), 63);
    chk("a_load_low", int'(eng_load), 0);
    tick();
    chk("a_end_round_ing", int'(round_ing), 0);
    chk("a_end_idx", int'(round_idx), 0);
    eng_rdy = 1'b1;
    #1;
    chk("a_inflight_hold", int'(inflight), 1);
    tick();
    eng_rdy = 1'b0;
    #1;
    chk("a_rsp0", int'(rsp0_valid), 1);
    chk("a_rsp1", int'(rsp1_valid), 0);
    chk("a_inflight_0", int'(inflight), 0);
    tick();
    chk("a_rsp0_pulse", int'(rsp0_valid), 0);

    rstb = 1'b0;
    tick();
    rstb = 1'b1;
    tick();

    // Both requesters valid: alternating grants, back-to-back jobs.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("b_g0_ready0", int'(req0_ready), 1);
    chk("b_g0_ready1", int'(req1_ready), 0);
    tick();
    chk("b_g0_load", int'(eng_load), 1);
    chk("b_g0_sel", int'(eng_sel), 0);
    run_rounds(63, "b_run0");
    chk("b_g1_ready1", int'(req1_ready), 1);
    chk("b_g1_ready0", int'(req0_ready), 0);
    chk("b_g1_inflight", int'(inflight), 1);
    tick();
    chk("b_g1_round_ing", int'(round_ing), 1);
    chk("b_g1_idx_wrap", int'(round_idx), 0);
    chk("b_g1_load", int'(eng_load), 1);
    chk("b_g1_sel", int'(eng_sel), 1);
    chk("b_g1_inflight", int'(inflight), 2);
    run_rounds(63, "b_run1");
    chk("b_full_ready0", int'(req0_ready), 0);
    chk("b_full_ready1", int'(req1_ready), 0);
    tick();
    chk("b_full_idle", int'(round_ing), 0);
    chk("b_full_inflight", int'(inflight), 2);
    chk("b_idle_full_ready0", int'(req0_ready), 0);
    eng_rdy = 1'b1;
    #1;
    chk("b_g2_ready0", int'(req0_ready), 1);
    chk("b_g2_ready1", int'(req1_ready), 0);
    tick();
    eng_rdy = 1'b0;
    #1;
    chk("b_g2_rsp0", int'(rsp0_valid), 1);
    chk("b_g2_inflight", int'(inflight), 2);
    chk("b_g2_load", int'(eng_load), 1);
    chk("b_g2_sel", int'(eng_sel), 0);
    run_rounds(63, "b_run2");
    eng_rdy = 1'b1;
    #1;
    chk("b_g3_ready1", int'(req1_ready), 1);
    chk("b_g3_ready0", int'(req0_ready), 0);
    tick();
    eng_rdy    = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("b_g3_rsp1", int'(rsp1_valid), 1);
    chk("b_g3_rsp0", int'(rsp0_valid), 0);
    chk("b_g3_round_ing", int'(round_ing), 1);
    chk("b_g3_idx", int'(round_idx), 0);
    chk("b_g3_inflight", int'(inflight), 2);
    chk("b_g3_sel", int'(eng_sel), 1);

    // Drain: FIFO order is tag 0 then tag 1.
    eng_rdy = 1'b1;
    tick();
    eng_rdy = 1'b0;
    #1;
    chk("d_rsp0", int'(rsp0_valid), 1);
    chk("d_rsp1_low", int'(rsp1_valid), 0);
    chk("d_inflight1", int'(inflight), 1);
    eng_rdy = 1'b1;
    tick();
    eng_rdy = 1'b0;
    #1;
    chk("d_rsp1", int'(rsp1_valid), 1);
    chk("d_rsp0_low", int'(rsp0_valid), 0);
    chk("d_inflight0", int'(inflight), 0);

    // clr aborts the running job; both valid during clr gets no grant.
    clr        = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("c_clr_ready0", int'(req0_ready), 0);
    chk("c_clr_ready1", int'(req1_ready), 0);
    tick();
    clr = 1'b0;
    #1;
    chk("c_clr_round_ing", int'(round_ing), 0);
    chk("c_clr_idx", int'(round_idx), 0);
    chk("c_ready0", int'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("c_inflight1", int'(inflight), 1);
    run_rounds(30, "c_run");
    chk("c_idx30", int'(round_idx), 30);
    clr        = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("c_clr30_ready0", int'(req0_ready), 0);
    chk("c_clr30_ready1", int'(req1_ready), 0);
    tick();
    clr        = 1'b0;
    #1;
    chk("c_abort_round_ing", int'(round_ing), 0);
    chk("c_abort_inflight", int'(inflight), 0);
    chk("c_abort_load", int'(eng_load), 0);
    chk("c_abort_idx", int'(round_idx), 0);
    chk("c_ptr_kept_ready1", int'(req1_ready), 1);
    chk("c_ptr_kept_ready0", int'(req0_ready), 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Unexpected engine result after the flush.
    eng_rdy = 1'b1;
    tick();
    eng_rdy = 1'b0;
    #1;
    chk("e_err_set", int'(err_unexp), 1);
    chk("e_rsp0", int'(rsp0_valid), 0);
    chk("e_rsp1", int'(rsp1_valid), 0);
    chk("e_inflight", int'(inflight), 0);
    tick();
    tick();
    chk("e_err_held", int'(err_unexp), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    chk("e_err_after_clr", int'(err_unexp), 1);
    rstb = 1'b0;
    #1;
    chk("e_err_async_rst", int'(err_unexp), 0);
    chk("e_inflight_rst", int'(inflight), 0);
    tick();
    rstb = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
